// File: rtl/ysyx_2022040010_id_ex_pkg.sv
// Shared constants, shift-op encodings and the EX payload record for the
// ID->EX pipeline register.
package ysyx_2022040010_id_ex_pkg;

    localparam int XLEN      = 64;
    localparam int RIDX      = 5;
    localparam int SHAMT64_W = 6;
    localparam int SHAMT32_W = 5;

    // One-hot shifter operation encodings
    localparam logic [2:0] SHIFT_SLL  = 3'b100;
    localparam logic [2:0] SHIFT_SRL  = 3'b010;
    localparam logic [2:0] SHIFT_SRA  = 3'b001;
    localparam logic [2:0] SHIFT_NONE = 3'b000;

    // Everything EX sees besides the valid bit
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] operand;
        logic [XLEN-1:0] amount;
        logic [XLEN-1:0] src2;
        logic [2:0]      shift_op;
        logic            alu_32;
        logic [RIDX-1:0] rd_idx;
        logic            rd_wen;
        logic            is_load;
    } ex_payload_t;

    // The shifter shifts by the full 64-bit amount, so only the legal
    // shamt bits may survive: 5 bits for W-form ops, 6 bits otherwise.
    function automatic logic [XLEN-1:0] mask_shamt(
        input logic [SHAMT64_W-1:0] low_bits,
        input logic                 is_32
    );
        logic [XLEN-1:0] amt;
        if (is_32) begin
            amt = {{(XLEN-SHAMT32_W){1'b0}}, low_bits[SHAMT32_W-1:0]};
        end else begin
            amt = {{(XLEN-SHAMT64_W){1'b0}}, low_bits};
        end
        return amt;
    endfunction

endpackage

// File: rtl/ysyx_2022040010_id_ex_fwd_mux.sv
// Operand bypass selector: x0, then the post-EX stage (non-load only),
// then write-back, then the register-file read data.
module ysyx_2022040010_fwd_mux
    import ysyx_2022040010_id_ex_pkg::*;
(
    input  logic [RIDX-1:0] i_idx,
    input  logic [XLEN-1:0] i_rf_data,
    input  logic [RIDX-1:0] i_exm_rd_idx,
    input  logic            i_exm_rd_wen,
    input  logic            i_exm_is_load,
    input  logic [XLEN-1:0] i_exm_result,
    input  logic [RIDX-1:0] i_wb_rd_idx,
    input  logic            i_wb_rd_wen,
    input  logic [XLEN-1:0] i_wb_result,
    output logic [XLEN-1:0] o_operand
);

    // Priority bypass selection; a load in exm has no data yet and is skipped
    always_comb begin
        o_operand = i_rf_data;
        if (i_idx == {RIDX{1'b0}}) begin
            o_operand = {XLEN{1'b0}};
        end else if (i_exm_rd_wen && !i_exm_is_load && (i_exm_rd_idx == i_idx)) begin
            o_operand = i_exm_result;
        end else if (i_wb_rd_wen && (i_wb_rd_idx == i_idx)) begin
            o_operand = i_wb_result;
        end else begin
            o_operand = i_rf_data;
        end
    end

endmodule

// File: rtl/ysyx_2022040010_id_ex.sv
// ID->EX pipeline register: operand forwarding, load-use bubble insertion,
// branch flush and registered, pre-masked shifter operands for EX.
module ysyx_2022040010_id_ex
    import ysyx_2022040010_id_ex_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [RIDX-1:0] id_rs1_idx,
    input  logic [RIDX-1:0] id_rs2_idx,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_use_imm,
    input  logic [RIDX-1:0] id_rd_idx,
    input  logic            id_rd_wen,
    input  logic            id_is_load,
    input  logic [2:0]      id_shift_op,
    input  logic            id_alu_32,
    input  logic [RIDX-1:0] exm_rd_idx,
    input  logic            exm_rd_wen,
    input  logic            exm_is_load,
    input  logic [XLEN-1:0] exm_result,
    input  logic [RIDX-1:0] wb_rd_idx,
    input  logic            wb_rd_wen,
    input  logic [XLEN-1:0] wb_result,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] shift_operand,
    output logic [XLEN-1:0] shift_amount,
    output logic [XLEN-1:0] ex_src2,
    output logic [2:0]      shift_op,
    output logic            alu_32,
    output logic [RIDX-1:0] ex_rd_idx,
    output logic            ex_rd_wen,
    output logic            ex_is_load,
    output logic [31:0]     bubble_cnt
);

    logic            r_ex_valid;
    ex_payload_t     r_payload;
    logic [31:0]     r_bubble_cnt;

    logic [XLEN-1:0] w_rs1_fwd;
    logic [XLEN-1:0] w_rs2_fwd;
    logic [XLEN-1:0] w_src2;
    logic            w_rs1_haz;
    logic            w_rs2_haz;
    logic            w_hazard;
    logic            w_ex_free;
    logic            w_load;
    ex_payload_t     w_next;

    ysyx_2022040010_fwd_mux u_fwd_rs1 (
        .i_idx         (id_rs1_idx),
        .i_rf_data     (id_rs1_data),
        .i_exm_rd_idx  (exm_rd_idx),
        .i_exm_rd_wen  (exm_rd_wen),
        .i_exm_is_load (exm_is_load),
        .i_exm_result  (exm_result),
        .i_wb_rd_idx   (wb_rd_idx),
        .i_wb_rd_wen   (wb_rd_wen),
        .i_wb_result   (wb_result),
        .o_operand     (w_rs1_fwd)
    );

    ysyx_2022040010_fwd_mux u_fwd_rs2 (
        .i_idx         (id_rs2_idx),
        .i_rf_data     (id_rs2_data),
        .i_exm_rd_idx  (exm_rd_idx),
        .i_exm_rd_wen  (exm_rd_wen),
        .i_exm_is_load (exm_is_load),
        .i_exm_result  (exm_result),
        .i_wb_rd_idx   (wb_rd_idx),
        .i_wb_rd_wen   (wb_rd_wen),
        .i_wb_result   (wb_result),
        .o_operand     (w_rs2_fwd)
    );

    // A source is stalled when a load that has not produced data targets it
    function automatic logic load_use_hit(input logic [RIDX-1:0] idx);
        logic hit;
        hit = 1'b0;
        if (idx == {RIDX{1'b0}}) begin
            hit = 1'b0;
        end else begin
            hit = (r_ex_valid && r_payload.is_load && r_payload.rd_wen &&
                   (r_payload.rd_idx == idx)) ||
                  (exm_is_load && exm_rd_wen && (exm_rd_idx == idx));
        end
        return hit;
    endfunction

    // Load-use hazard detection; rs2 is not read when the immediate is used
    always_comb begin
        w_rs1_haz = load_use_hit(id_rs1_idx);
        w_rs2_haz = 1'b0;
        if (id_use_imm) begin
            w_rs2_haz = 1'b0;
        end else begin
            w_rs2_haz = load_use_hit(id_rs2_idx);
        end
        w_hazard = id_valid && (w_rs1_haz || w_rs2_haz);
    end

    // Handshake: the register may update when empty or being drained
    always_comb begin
        w_ex_free = !r_ex_valid || ex_ready;
        id_ready  = flush || (w_ex_free && !w_hazard);
        w_load    = !flush && w_ex_free && !w_hazard && id_valid;
    end

    // Assemble the next EX payload from the forwarded operands
    always_comb begin
        w_src2          = id_use_imm ? id_imm : w_rs2_fwd;
        w_next          = '0;
        w_next.pc       = id_pc;
        w_next.operand  = w_rs1_fwd;
        w_next.amount   = mask_shamt(w_src2[SHAMT64_W-1:0], id_alu_32);
        w_next.src2     = w_src2;
        w_next.shift_op = id_shift_op;
        w_next.alu_32   = id_alu_32;
        w_next.rd_idx   = id_rd_idx;
        w_next.rd_wen   = id_rd_wen;
        w_next.is_load  = id_is_load;
    end

    // Valid bit and bubble counter; flush wins over hazard and stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid   <= 1'b0;
            r_bubble_cnt <= 32'd0;
        end else if (flush) begin
            r_ex_valid   <= 1'b0;
        end else if (w_ex_free) begin
            if (w_hazard) begin
                r_ex_valid   <= 1'b0;
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end else begin
                r_ex_valid   <= id_valid;
            end
        end
    end

    // Payload register, loaded only on an accepted instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_payload <= '0;
        end else if (w_load) begin
            r_payload <= w_next;
        end
    end

    assign ex_valid      = r_ex_valid;
    assign ex_pc         = r_payload.pc;
    assign shift_operand = r_payload.operand;
    assign shift_amount  = r_payload.amount;
    assign ex_src2       = r_payload.src2;
    assign shift_op      = r_payload.shift_op;
    assign alu_32        = r_payload.alu_32;
    assign ex_rd_idx     = r_payload.rd_idx;
    assign ex_rd_wen     = r_payload.rd_wen;
    assign ex_is_load    = r_payload.is_load;
    assign bubble_cnt    = r_bubble_cnt;

endmodule

// File: tb/tb_ysyx_2022040010_id_ex.sv
// Self-checking bench: directed vector table, hand-written hazard/stall/
// flush/reset sequences and randomized traffic against a reference model.
module tb_ysyx_2022040010_id_ex;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_pc;
    logic [4:0]  id_rs1_idx, id_rs2_idx;
    logic [63:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_use_imm;
    logic [4:0]  id_rd_idx;
    logic        id_rd_wen, id_is_load;
    logic [2:0]  id_shift_op;
    logic        id_alu_32;
    logic [4:0]  exm_rd_idx;
    logic        exm_rd_wen, exm_is_load;
    logic [63:0] exm_result;
    logic [4:0]  wb_rd_idx;
    logic        wb_rd_wen;
    logic [63:0] wb_result;
    logic        flush, ex_ready;
    logic        ex_valid;
    logic [63:0] ex_pc, shift_operand, shift_amount, ex_src2;
    logic [2:0]  shift_op;
    logic        alu_32;
    logic [4:0]  ex_rd_idx;
    logic        ex_rd_wen, ex_is_load;
    logic [31:0] bubble_cnt;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_2022040010_id_ex dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_rd_idx(id_rd_idx),
        .id_rd_wen(id_rd_wen), .id_is_load(id_is_load),
        .id_shift_op(id_shift_op), .id_alu_32(id_alu_32),
        .exm_rd_idx(exm_rd_idx), .exm_rd_wen(exm_rd_wen),
        .exm_is_load(exm_is_load), .exm_result(exm_result),
        .wb_rd_idx(wb_rd_idx), .wb_rd_wen(wb_rd_wen), .wb_result(wb_result),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .shift_operand(shift_operand), .shift_amount(shift_amount),
        .ex_src2(ex_src2), .shift_op(shift_op), .alu_32(alu_32),
        .ex_rd_idx(ex_rd_idx), .ex_rd_wen(ex_rd_wen), .ex_is_load(ex_is_load),
        .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1_idx;
        logic [63:0] rs1_data;
        logic [4:0]  rs2_idx;
        logic [63:0] rs2_data;
        logic [63:0] imm;
        logic        use_imm;
        logic [2:0]  sop;
        logic        a32;
        logic [4:0]  exm_idx;
        logic        exm_wen;
        logic [63:0] exm_res;
        logic [4:0]  wb_idx;
        logic        wb_wen;
        logic [63:0] wb_res;
        logic [63:0] exp_opnd;
        logic [63:0] exp_amt;
        logic [63:0] exp_src2;
    } vec_t;

    localparam int NV = 9;
    vec_t vec [NV];

    // reference model state
    logic        m_valid;
    logic [63:0] m_pc, m_opnd, m_amt, m_src2;
    logic [2:0]  m_sop;
    logic        m_a32;
    logic [4:0]  m_rd;
    logic        m_wen, m_ld;
    logic [31:0] m_bc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        id_valid = 1'b0; id_pc = 64'h0; id_rs1_idx = 5'd0; id_rs2_idx = 5'd0;
        id_rs1_data = 64'h0; id_rs2_data = 64'h0; id_imm = 64'h0;
        id_use_imm = 1'b0; id_rd_idx = 5'd0; id_rd_wen = 1'b0;
        id_is_load = 1'b0; id_shift_op = 3'b000; id_alu_32 = 1'b0;
        exm_rd_idx = 5'd0; exm_rd_wen = 1'b0; exm_is_load = 1'b0;
        exm_result = 64'h0; wb_rd_idx = 5'd0; wb_rd_wen = 1'b0;
        wb_result = 64'h0; flush = 1'b0; ex_ready = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_pc = 64'h0; m_opnd = 64'h0; m_amt = 64'h0;
        m_src2 = 64'h0; m_sop = 3'b000; m_a32 = 1'b0; m_rd = 5'd0;
        m_wen = 1'b0; m_ld = 1'b0; m_bc = 32'd0;
    endtask

    function automatic logic [63:0] ref_fwd(input logic [4:0] idx, input logic [63:0] rf);
        if (idx == 5'd0) return 64'h0;
        if (exm_rd_wen && !exm_is_load && exm_rd_idx == idx) return exm_result;
        if (wb_rd_wen && wb_rd_idx == idx) return wb_result;
        return rf;
    endfunction

    function automatic bit ref_pending_load(input logic [4:0] idx);
        if (idx == 5'd0) return 1'b0;
        return (m_valid && m_ld && m_wen && m_rd == idx) ||
               (exm_is_load && exm_rd_wen && exm_rd_idx == idx);
    endfunction

    task automatic randomize_inputs();
        logic [2:0] sops [4];
        sops[0] = 3'b100; sops[1] = 3'b010; sops[2] = 3'b001; sops[3] = 3'b000;
        id_valid    = ($urandom_range(0, 3) != 0);
        id_pc       = {$urandom(), $urandom()};
        id_rs1_idx  = 5'($urandom_range(0, 3));
        id_rs2_idx  = 5'($urandom_range(0, 3));
        id_rs1_data = {$urandom(), $urandom()};
        id_rs2_data = {$urandom(), $urandom()};
        id_imm      = {$urandom(), $urandom()};
        id_use_imm  = 1'($urandom_range(0, 1));
        id_rd_idx   = 5'($urandom_range(0, 3));
        id_rd_wen   = 1'($urandom_range(0, 1));
        id_is_load  = ($urandom_range(0, 2) == 0);
        id_shift_op = sops[$urandom_range(0, 3)];
        id_alu_32   = 1'($urandom_range(0, 1));
        exm_rd_idx  = 5'($urandom_range(0, 3));
        exm_rd_wen  = 1'($urandom_range(0, 1));
        exm_is_load = ($urandom_range(0, 3) == 0);
        exm_result  = {$urandom(), $urandom()};
        wb_rd_idx   = 5'($urandom_range(0, 3));
        wb_rd_wen   = 1'($urandom_range(0, 1));
        wb_result   = {$urandom(), $urandom()};
        flush       = ($urandom_range(0, 15) == 0);
        ex_ready    = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        logic [63:0] e_opnd, e_src2, e_amt;
        logic        e_haz, e_free, e_rdy;
        logic [63:0] held;

        // directed vectors
        vec[0] = '{5'd5, 64'h1, 5'd0, 64'h0, 64'h47, 1'b1, 3'b100, 1'b0,
                   5'd0, 1'b0, 64'h0, 5'd0, 1'b0, 64'h0, 64'h1, 64'h7, 64'h47};
        vec[1] = '{5'd8, 64'h123, 5'd6, 64'hFFFF_FFFF_FFFF_FFE3, 64'h0, 1'b0, 3'b010, 1'b1,
                   5'd0, 1'b0, 64'h0, 5'd0, 1'b0, 64'h0,
                   64'h123, 64'h3, 64'hFFFF_FFFF_FFFF_FFE3};
        vec[2] = '{5'd7, 64'h11, 5'd0, 64'h0, 64'h5, 1'b1, 3'b100, 1'b0,
                   5'd7, 1'b1, 64'hAA, 5'd7, 1'b1, 64'hBB, 64'hAA, 64'h5, 64'h5};
        vec[3] = '{5'd0, 64'h55, 5'd0, 64'h0, 64'h21, 1'b1, 3'b001, 1'b1,
                   5'd0, 1'b1, 64'hCC, 5'd0, 1'b1, 64'hDD, 64'h0, 64'h1, 64'h21};
        vec[4] = '{5'd7, 64'h11, 5'd0, 64'h0, 64'h3, 1'b1, 3'b010, 1'b0,
                   5'd7, 1'b0, 64'hAA, 5'd7, 1'b1, 64'hBB, 64'hBB, 64'h3, 64'h3};
        vec[5] = '{5'd2, 64'h200, 5'd3, 64'h1, 64'h0, 1'b0, 3'b001, 1'b0,
                   5'd3, 1'b1, 64'h3F, 5'd3, 1'b1, 64'h40, 64'h200, 64'h3F, 64'h3F};
        vec[6] = '{5'd2, 64'h200, 5'd3, 64'h1, 64'h0, 1'b0, 3'b100, 1'b0,
                   5'd0, 1'b0, 64'h0, 5'd3, 1'b1, 64'h40, 64'h200, 64'h0, 64'h40};
        vec[7] = '{5'd1, 64'hDEAD, 5'd0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'b000, 1'b1,
                   5'd0, 1'b0, 64'h0, 5'd0, 1'b0, 64'h0,
                   64'hDEAD, 64'h1F, 64'hFFFF_FFFF_FFFF_FFFF};
        vec[8] = '{5'd1, 64'h5, 5'd0, 64'h3, 64'h0, 1'b0, 3'b100, 1'b0,
                   5'd0, 1'b1, 64'h7, 5'd0, 1'b0, 64'h0, 64'h5, 64'h0, 64'h0};

        // reset
        clear_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst_ex_valid", 64'(ex_valid), 64'h0);
        chk("rst_shift_op", 64'(shift_op), 64'h0);
        chk("rst_bubble_cnt", 64'(bubble_cnt), 64'h0);
        chk("rst_shift_operand", shift_operand, 64'h0);
        chk("rst_id_ready", 64'(id_ready), 64'h1);
        rst_n = 1'b1;
        step();

        // table-driven single transfers, back to back
        for (int i = 0; i < NV; i++) begin
            clear_inputs();
            id_valid = 1'b1;
            id_pc = 64'h8000_0000 + 64'(i) * 64'd4;
            id_rs1_idx = vec[i].rs1_idx; id_rs1_data = vec[i].rs1_data;
            id_rs2_idx = vec[i].rs2_idx; id_rs2_data = vec[i].rs2_data;
            id_imm = vec[i].imm; id_use_imm = vec[i].use_imm;
            id_shift_op = vec[i].sop; id_alu_32 = vec[i].a32;
            exm_rd_idx = vec[i].exm_idx; exm_rd_wen = vec[i].exm_wen;
            exm_result = vec[i].exm_res;
            wb_rd_idx = vec[i].wb_idx; wb_rd_wen = vec[i].wb_wen;
            wb_result = vec[i].wb_res;
            #1;
            chk("vec_id_ready", 64'(id_ready), 64'h1);
            step();
            chk("vec_ex_valid", 64'(ex_valid), 64'h1);
            chk("vec_ex_pc", ex_pc, 64'h8000_0000 + 64'(i) * 64'd4);
            chk("vec_shift_operand", shift_operand, vec[i].exp_opnd);
            chk("vec_shift_amount", shift_amount, vec[i].exp_amt);
            chk("vec_ex_src2", ex_src2, vec[i].exp_src2);
            chk("vec_shift_op", 64'(shift_op), 64'(vec[i].sop));
            chk("vec_alu_32", 64'(alu_32), 64'(vec[i].a32));
        end

        // load-use: load to x9, then a consumer of x9
        clear_inputs();
        id_valid = 1'b1; id_rs1_idx = 5'd1; id_rs1_data = 64'h10; id_use_imm = 1'b1;
        id_rd_idx = 5'd9; id_rd_wen = 1'b1; id_is_load = 1'b1;
        step();
        chk("ld_ex_is_load", 64'(ex_is_load), 64'h1);
        chk("ld_ex_rd_idx", 64'(ex_rd_idx), 64'd9);
        clear_inputs();
        id_valid = 1'b1; id_rs1_idx = 5'd9; id_rs1_data = 64'h1; id_use_imm = 1'b1;
        id_imm = 64'h2; id_shift_op = 3'b100;
        #1;
        chk("lu_id_ready_low", 64'(id_ready), 64'h0);
        step();
        chk("lu_bubble_valid", 64'(ex_valid), 64'h0);
        chk("lu_bubble_cnt", 64'(bubble_cnt), 64'd1);
        wb_rd_idx = 5'd9; wb_rd_wen = 1'b1; wb_result = 64'h99;
        #1;
        chk("lu_id_ready_high", 64'(id_ready), 64'h1);
        step();
        chk("lu_accept_valid", 64'(ex_valid), 64'h1);
        chk("lu_accept_operand", shift_operand, 64'h99);
        chk("lu_accept_amount", shift_amount, 64'h2);
        chk("lu_cnt_after", 64'(bubble_cnt), 64'd1);

        // load to x4 held in EX by a 3-cycle stall while ID wants x4
        clear_inputs();
        id_valid = 1'b1; id_rs1_idx = 5'd1; id_rs1_data = 64'h10; id_use_imm = 1'b1;
        id_rd_idx = 5'd4; id_rd_wen = 1'b1; id_is_load = 1'b1;
        step();
        held = shift_operand;
        chk("st_held_operand", held, 64'h10);
        clear_inputs();
        id_valid = 1'b1; id_rs1_idx = 5'd4; id_rs1_data = 64'h3; id_use_imm = 1'b1;
        ex_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("st_id_ready", 64'(id_ready), 64'h0);
            step();
            chk("st_ex_valid", 64'(ex_valid), 64'h1);
            chk("st_operand_stable", shift_operand, 64'h10);
            chk("st_rd_stable", 64'(ex_rd_idx), 64'd4);
            chk("st_no_bubble", 64'(bubble_cnt), 64'd1);
        end
        flush = 1'b1;
        #1;
        chk("fl_id_ready", 64'(id_ready), 64'h1);
        step();
        chk("fl_ex_valid", 64'(ex_valid), 64'h0);
        chk("fl_no_bubble", 64'(bubble_cnt), 64'd1);
        flush = 1'b0; id_valid = 1'b0;
        #1;
        chk("fl_id_ready_after", 64'(id_ready), 64'h1);

        // hazard counted only once the stalled register drains
        clear_inputs();
        id_valid = 1'b1; id_rs1_idx = 5'd2; id_use_imm = 1'b1;
        id_rd_idx = 5'd4; id_rd_wen = 1'b1; id_is_load = 1'b1;
        step();
        clear_inputs();
        id_valid = 1'b1; id_rs2_idx = 5'd4; ex_ready = 1'b0;
        step();
        chk("hs_stall_cnt", 64'(bubble_cnt), 64'd1);
        ex_ready = 1'b1;
        step();
        chk("hs_release_cnt", 64'(bubble_cnt), 64'd2);
        chk("hs_release_valid", 64'(ex_valid), 64'h0);

        // randomized traffic against the reference model
        clear_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        step();
        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            e_opnd = ref_fwd(id_rs1_idx, id_rs1_data);
            e_src2 = id_use_imm ? id_imm : ref_fwd(id_rs2_idx, id_rs2_data);
            e_amt  = id_alu_32 ? (e_src2 % 64'd32) : (e_src2 % 64'd64);
            e_haz  = id_valid && (ref_pending_load(id_rs1_idx) ||
                                  (!id_use_imm && ref_pending_load(id_rs2_idx)));
            e_free = !m_valid || ex_ready;
            e_rdy  = flush || (e_free && !e_haz);
            #1;
            chk("rnd_id_ready", 64'(id_ready), 64'(e_rdy));
            if (flush) begin
                m_valid = 1'b0;
            end else if (e_free) begin
                if (e_haz) begin
                    m_valid = 1'b0;
                    m_bc = m_bc + 32'd1;
                end else begin
                    m_valid = id_valid;
                    if (id_valid) begin
                        m_pc = id_pc; m_opnd = e_opnd; m_amt = e_amt; m_src2 = e_src2;
                        m_sop = id_shift_op; m_a32 = id_alu_32; m_rd = id_rd_idx;
                        m_wen = id_rd_wen; m_ld = id_is_load;
                    end
                end
            end
            step();
            chk("rnd_ex_valid", 64'(ex_valid), 64'(m_valid));
            chk("rnd_ex_pc", ex_pc, m_pc);
            chk("rnd_shift_operand", shift_operand, m_opnd);
            chk("rnd_shift_amount", shift_amount, m_amt);
            chk("rnd_ex_src2", ex_src2, m_src2);
            chk("rnd_shift_op", 64'(shift_op), 64'(m_sop));
            chk("rnd_alu_32", 64'(alu_32), 64'(m_a32));
            chk("rnd_rd", 64'({ex_rd_idx, ex_rd_wen, ex_is_load}), 64'({m_rd, m_wen, m_ld}));
            chk("rnd_bubble_cnt", 64'(bubble_cnt), 64'(m_bc));
        end

        // asynchronous reset in the middle of an EX stall
        clear_inputs();
        id_valid = 1'b1; id_pc = 64'h1000; id_use_imm = 1'b1; id_imm = 64'h5;
        id_shift_op = 3'b010;
        step();
        id_valid = 1'b0; ex_ready = 1'b0;
        step();
        chk("ar_pre_valid", 64'(ex_valid), 64'h1);
        chk("ar_pre_amount", shift_amount, 64'h5);
        rst_n = 1'b0;
        #1;
        chk("ar_ex_valid", 64'(ex_valid), 64'h0);
        chk("ar_ex_pc", ex_pc, 64'h0);
        chk("ar_shift_amount", shift_amount, 64'h0);
        chk("ar_shift_op", 64'(shift_op), 64'h0);
        chk("ar_bubble_cnt", 64'(bubble_cnt), 64'h0);
        chk("ar_id_ready", 64'(id_ready), 64'h1);
        #2;
        rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
